write_req_gen: RTL

WRITE_REQ_GEN -- requirements
Module: write_req_gen

---
 rtl/write_req_gen_if.sv | 30 +++
 rtl/write_req_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/write_req_gen_if.sv
// Handshake bundle between a pixel producer, the write request generator and the memory write port.
// The master view belongs to the generator; the slave view to the environment driving it.
interface write_req_gen_if;
  logic         frame_start_in;
  logic [127:0] data_in;
  logic         valid_data_in;
  logic         ready_data_out;
  logic [26:0]  write_request_address_out;
  logic [127:0] write_data_out;
  logic         valid_write_req_out;
  logic         rdy_write_req_in;
  logic         valid_write_resp_in;
  logic         rdy_write_resp_out;
  logic         busy_out;
  logic         last_req_out;
  logic         frame_done_out;
  logic         error_out;

  modport master (
    input  frame_start_in, data_in, valid_data_in, rdy_write_req_in, valid_write_resp_in,
    output ready_data_out, write_request_address_out, write_data_out, valid_write_req_out,
           rdy_write_resp_out, busy_out, last_req_out, frame_done_out, error_out
  );

  modport slave (
    output frame_start_in, data_in, valid_data_in, rdy_write_req_in, valid_write_resp_in,
    input  ready_data_out, write_request_address_out, write_data_out, valid_write_req_out,
           rdy_write_resp_out, busy_out, last_req_out, frame_done_out, error_out
  );
endinterface

// File: rtl/write_req_gen.sv
// Turns a stream of 128-bit pixel words into sequential memory write requests for one frame,
// bounding the number of unacknowledged writes and flagging acknowledgements with nothing outstanding.
module write_req_gen #(
  parameter int unsigned FRAME_WORDS  = 115200,
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter logic [26:0] BASE_ADDR    = 27'd0
) (
  input logic             clk_in,
  input logic             rst_n_in,
  write_req_gen_if.master bus
);
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [INF_W-1:0] INF_MAX   = INF_W'(MAX_INFLIGHT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] acc_count;
  logic [CNT_W-1:0] req_count;
  logic [CNT_W-1:0] resp_count;
  logic [INF_W-1:0] inflight;
  logic             error_q;

  logic             vld_p1;
  logic             last_p1;
  logic [26:0]      addr_p1;
  logic [127:0]     data_p1;

  logic             resp_open;
  logic             ready;
  logic             data_acc;
  logic             req_hs;
  logic             resp_hs;
  logic             resp_ok;

  // Byte address of a word index; wraps silently at 27 bits.
  function automatic logic [26:0] word_addr(input logic [CNT_W-1:0] idx);
    logic [26:0] ext;
    ext = 27'(idx);
    return BASE_ADDR + (ext << 4);
  endfunction

  assign resp_open = (state == S_RUN) || (state == S_DRAIN);
  assign ready     = (state == S_RUN) && (!vld_p1 || bus.rdy_write_req_in) &&
                     (inflight < INF_MAX) && (acc_count < FRAME_CNT);
  assign data_acc  = ready && bus.valid_data_in;
  assign req_hs    = vld_p1 && bus.rdy_write_req_in;
  assign resp_hs   = bus.valid_write_resp_in && resp_open;
  assign resp_ok   = resp_hs && (inflight != '0);

  // Frame control: state, counters and the sticky error flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= S_IDLE;
      acc_count  <= '0;
      req_count  <= '0;
      resp_count <= '0;
      inflight   <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (bus.frame_start_in) state <= S_RUN;
        S_RUN:   if (req_hs && (req_count == LAST_IDX)) state <= S_DRAIN;
        S_DRAIN: if (resp_count == FRAME_CNT) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (data_acc) acc_count  <= acc_count + CNT_W'(1);
      if (req_hs)   req_count  <= req_count + CNT_W'(1);
      if (resp_ok)  resp_count <= resp_count + CNT_W'(1);
      if (resp_hs && (inflight == '0)) error_q <= 1'b1;

      case ({data_acc, resp_ok})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase

      if ((state == S_IDLE) && bus.frame_start_in) begin
        acc_count  <= '0;
        req_count  <= '0;
        resp_count <= '0;
        inflight   <= '0;
        error_q    <= 1'b0;
      end
    end
  end

  // Stage p1: the pending write request, held until the memory takes it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (data_acc) begin
      vld_p1  <= 1'b1;
      last_p1 <= (acc_count == LAST_IDX);
      addr_p1 <= word_addr(acc_count);
      data_p1 <= bus.data_in;
    end else if (req_hs) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.ready_data_out            = ready;
  assign bus.write_request_address_out = addr_p1;
  assign bus.write_data_out            = data_p1;
  assign bus.valid_write_req_out       = vld_p1;
  assign bus.last_req_out              = vld_p1 && last_p1;
  assign bus.rdy_write_resp_out        = resp_open;
  assign bus.busy_out                  = resp_open;
  assign bus.frame_done_out            = (state == S_DONE);
  assign bus.error_out                 = error_q;
endmodule
